// File: rtl/alu_wb_queue.sv
// alu_wb_queue: in-order writeback FIFO sitting between the PE ALU and the
// register file. Holds each result (value, zero flag, destination register)
// until the register file takes it over a valid/ready port. Issue logic can
// look up the youngest pending value for a source register.
module alu_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       res_valid,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       res_zero,
  input  logic [REG_W-1:0]           res_rd,
  output logic                       res_ready,
  output logic                       wb_valid,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       wb_zero,
  output logic [REG_W-1:0]           wb_rd,
  input  logic                       wb_ready,
  input  logic [REG_W-1:0]           fwd_rs,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Pointer/count/flag state; count is one bit wider than the pointers so
  // that full and empty are distinguishable.
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DEPTH-1:0]  vld_q, vld_d;

  // Entry storage (no reset: contents are only meaningful while valid).
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic              mem_zero_q [DEPTH];
  logic              mem_zero_d [DEPTH];
  logic [REG_W-1:0]  mem_rd_q   [DEPTH];
  logic [REG_W-1:0]  mem_rd_d   [DEPTH];

  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              store_s;
  logic              pop_s;
  logic              fwd_hit_s;
  logic [DATA_W-1:0] fwd_data_s;

  assign empty_s = (count_q == {CW{1'b0}});
  assign full_s  = (count_q == CW'(DEPTH));

  // Handshakes; flush suppresses both sides. Results for x0 consume the
  // handshake but are never stored.
  assign push_s  = res_valid & ~full_s & ~flush;
  assign store_s = push_s & (res_rd != {REG_W{1'b0}});
  assign pop_s   = ~empty_s & wb_ready & ~flush;

  // Next-state for pointers, count, valid bits and the sticky overflow flag.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    vld_d      = vld_q;
    overflow_d = overflow_q;
    if (flush) begin
      head_d     = {AW{1'b0}};
      tail_d     = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      vld_d      = {DEPTH{1'b0}};
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q | (res_valid & full_s);
      head_d     = pop_s   ? head_q + AW'(1) : head_q;
      tail_d     = store_s ? tail_q + AW'(1) : tail_q;
      if (pop_s) begin
        vld_d[head_q] = 1'b0;
      end else begin
        vld_d = vld_d;
      end
      if (store_s) begin
        vld_d[tail_q] = 1'b1;
      end else begin
        vld_d = vld_d;
      end
      case ({store_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next-state for entry storage: write the tail slot on a stored push.
  always_comb begin
    mem_data_d = mem_data_q;
    mem_zero_d = mem_zero_q;
    mem_rd_d   = mem_rd_q;
    if (store_s) begin
      mem_data_d[tail_q] = res_data;
      mem_zero_d[tail_q] = res_zero;
      mem_rd_d[tail_q]   = res_rd;
    end else begin
      mem_data_d = mem_data_q;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= {AW{1'b0}};
      tail_q     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      vld_q      <= {DEPTH{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage register.
  always_ff @(posedge clk) begin
    mem_data_q <= mem_data_d;
    mem_zero_q <= mem_zero_d;
    mem_rd_q   <= mem_rd_d;
  end

  // Forwarding lookup: walk oldest to youngest so the youngest match wins.
  // Uses pre-edge state, so an entry popping this cycle still hits.
  always_comb begin
    logic [AW-1:0] idx_v;
    logic          match_v;
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DATA_W{1'b0}};
    idx_v      = head_q;
    match_v    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_v      = head_q + AW'(i);
      match_v    = (CW'(i) < count_q) && vld_q[idx_v] &&
                   (mem_rd_q[idx_v] == fwd_rs) && (fwd_rs != {REG_W{1'b0}});
      fwd_hit_s  = fwd_hit_s | match_v;
      fwd_data_s = match_v ? mem_data_q[idx_v] : fwd_data_s;
    end
  end

  assign res_ready = ~full_s;
  assign wb_valid  = ~empty_s;
  assign wb_data   = empty_s ? {DATA_W{1'b0}} : mem_data_q[head_q];
  assign wb_zero   = empty_s ? 1'b0 : mem_zero_q[head_q];
  assign wb_rd     = empty_s ? {REG_W{1'b0}} : mem_rd_q[head_q];
  assign fwd_hit   = fwd_hit_s;
  assign fwd_data  = fwd_data_s;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_wb_queue.sv
// tb_alu_wb_queue: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the writeback queue.
module tb_alu_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;
  logic [REG_W-1:0]  res_rd;
  logic              res_ready;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_zero;
  logic [REG_W-1:0]  wb_rd;
  logic              wb_ready;
  logic [REG_W-1:0]  fwd_rs;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [2:0]        count;
  logic              overflow;

  alu_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero),
    .res_rd(res_rd), .res_ready(res_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_zero(wb_zero),
    .wb_rd(wb_rd), .wb_ready(wb_ready),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              z;
    logic [REG_W-1:0]  rd;
  } ent_t;

  ent_t     model_q[$];
  bit       model_ovf;
  int       n_checks;
  int       n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model (state before the coming edge).
  task automatic check_outputs();
    bit                hit;
    logic [DATA_W-1:0] fdata;
    hit   = 1'b0;
    fdata = '0;
    foreach (model_q[i]) begin
      if (fwd_rs != 0 && model_q[i].rd == fwd_rs) begin
        hit   = 1'b1;
        fdata = model_q[i].d;
      end
    end
    check_eq("res_ready", 32'(res_ready), 32'(model_q.size() != DEPTH));
    check_eq("wb_valid",  32'(wb_valid),  32'(model_q.size() != 0));
    check_eq("count",     32'(count),     32'(model_q.size()));
    check_eq("overflow",  32'(overflow),  32'(model_ovf));
    check_eq("wb_data",   wb_data, (model_q.size() != 0) ? model_q[0].d : 32'h0);
    check_eq("wb_zero",   32'(wb_zero),  (model_q.size() != 0) ? 32'(model_q[0].z)  : 32'h0);
    check_eq("wb_rd",     32'(wb_rd),    (model_q.size() != 0) ? 32'(model_q[0].rd) : 32'h0);
    check_eq("fwd_hit",   32'(fwd_hit),  32'(hit));
    check_eq("fwd_data",  fwd_data, fdata);
  endtask

  // One clock cycle: drive, check, then advance the model across the edge.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit z,
                       input logic [REG_W-1:0] rd, input bit wbr,
                       input logic [REG_W-1:0] rs, input bit fl);
    bit rdy, push, pop;
    ent_t e;
    @(negedge clk);
    res_valid = v; res_data = d; res_zero = z; res_rd = rd;
    wb_ready = wbr; fwd_rs = rs; flush = fl;
    #1;
    check_outputs();
    rdy  = (model_q.size() != DEPTH);
    push = v && rdy;
    pop  = (model_q.size() != 0) && wbr;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (v && !rdy) model_ovf = 1'b1;
      if (pop) void'(model_q.pop_front());
      if (push && rd != 0) begin
        e.d = d; e.z = z; e.rd = rd;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic [REG_W-1:0] rs);
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, rs, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    n_checks = 0; n_errors = 0; model_ovf = 1'b0;
    rst_n = 1'b0; flush = 1'b0; res_valid = 1'b0; res_data = '0;
    res_zero = 1'b0; res_rd = '0; wb_ready = 1'b0; fwd_rs = '0;
    #12;
    check_eq("reset_count", 32'(count), 32'h0);
    check_eq("reset_ready", 32'(res_ready), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    idle(5'd0);

    // 1: async reset mid-stream with three entries queued
    cycle(1'b1, 32'h11, 1'b0, 5'd1, 1'b0, 5'd1, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 5'd2, 1'b0, 5'd2, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, 5'd3, 1'b0, 5'd3, 1'b0);
    idle(5'd2);
    check_eq("pre_reset_count", 32'(count), 32'h3);
    @(negedge clk); res_valid = 1'b0; wb_ready = 1'b0; #3;
    rst_n = 1'b0; #1;
    check_eq("rst_wb_valid", 32'(wb_valid), 32'h0);
    check_eq("rst_count",    32'(count),    32'h0);
    check_eq("rst_overflow", 32'(overflow), 32'h0);
    check_eq("rst_ready",    32'(res_ready), 32'h1);
    model_q.delete(); model_ovf = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cycle(1'b1, 32'h99, 1'b1, 5'd9, 1'b0, 5'd9, 1'b0);
    idle(5'd9);
    check_eq("post_reset_head", 32'(wb_rd), 32'd9);
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

    // 2: in-order writeback
    cycle(1'b1, 32'h10, 1'b0, 5'd1, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 32'h20, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 32'h30, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    check_eq("order_drained", 32'(count), 32'h0);

    // 3: fill past full, then flush
    for (int i = 1; i <= 5; i++) cycle(1'b1, 32'(i * 16), 1'b0, 5'(i), 1'b0, 5'd0, 1'b0);
    idle(5'd5);
    check_eq("full_overflow", 32'(overflow), 32'h1);
    check_eq("full_count",    32'(count),    32'h4);
    cycle(1'b1, 32'h77, 1'b0, 5'd7, 1'b1, 5'd0, 1'b1);
    idle(5'd0);
    check_eq("flush_count", 32'(count), 32'h0);

    // 4: results for x0 are dropped
    cycle(1'b1, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle(5'd0);
    check_eq("x0_count", 32'(count), 32'h0);

    // 5: forwarding youngest match
    cycle(1'b1, 32'hA, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
    idle(5'd5);
    check_eq("fwd5_data", fwd_data, 32'hC);
    idle(5'd6);
    idle(5'd0);
    idle(5'd7);
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

    // 6: steady push+pop across pointer wrap
    cycle(1'b1, 32'h5, 1'b0, 5'd4, 1'b0, 5'd4, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      d = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      cycle(1'b1, d, d == 0, 5'($urandom_range(1, 31)), 1'b1, 5'($urandom_range(0, 31)), 1'b0);
    end
    idle(5'd0);
    check_eq("wrap_count", 32'(count), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cycle($urandom_range(0, 3) != 0, d, d == 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 40) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
